bram_req_ctrl: RTL and testbench

- Request/response front end sitting directly upstream of the team's single-port block RAM with its two-stage registered read output (read latency 2).
- Accepts load/store requests over a valid/ready handshake, drives the RAM enables, and tracks reads in flight.
- Captures read data into a small response FIFO so the consumer (memory stage / loader) can apply backpressure without losing data.

---
 rtl/bram_req_pkg.sv | 19 +
 rtl/sync_fifo_fwft.sv | 60 ++++++
 rtl/bram_req_ctrl.sv | 92 +++++++++
 tb/tb_bram_req_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_req_pkg.sv
// Shared defaults and width helper for the block-RAM request controller.
package bram_req_pkg;

    localparam int RSP_DEPTH_DEFAULT = 4;

    // Bits needed to index `value` distinct items (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is always presented on dout
// while not empty. Pushes become visible the cycle after they are written.
module sync_fifo_fwft
    import bram_req_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = RSP_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         empty,
    output logic                         full,
    output logic [clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign count   = count_q;
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push & ~do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop & ~do_push) count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/bram_req_ctrl.sv
// Valid/ready front end for the single-port BRAM with two-stage registered
// read output; tracks loads in flight and buffers their data in order.
module bram_req_ctrl
    import bram_req_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RSP_DEPTH  = RSP_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic                  ram_rst,
    output logic                  ram_en2,
    output logic                  ram_rst2,
    input  logic [DATA_WIDTH-1:0] ram_do
);

    localparam int CNT_W = clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0] MAX_INFLIGHT = CNT_W'(RSP_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             s1_valid;
    logic             s2_valid;
    logic [CNT_W-1:0] inflight;
    logic             acc;
    logic             load_acc;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    // inflight covers pipeline plus FIFO, so gating on it alone prevents overflow.
    assign req_ready = rst_n & (inflight < MAX_INFLIGHT);
    assign acc       = req_valid & req_ready;
    assign load_acc  = acc & ~req_we;
    assign pop       = rsp_valid & rsp_ready;

    assign ram_en   = acc;
    assign ram_we   = acc & req_we;
    assign ram_addr = req_addr;
    assign ram_di   = req_wdata;
    assign ram_en2  = s1_valid;
    assign ram_rst  = ~rst_n;
    assign ram_rst2 = ~rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            inflight <= '0;
        end else begin
            s1_valid <= load_acc;
            s2_valid <= s1_valid;
            if (load_acc & ~pop)      inflight <= inflight + CNT_ONE;
            else if (pop & ~load_acc) inflight <= inflight - CNT_ONE;
        end
    end

    // s2_valid marks the cycle in which ram_do carries the load's data.
    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s2_valid),
        .din   (ram_do),
        .pop   (pop),
        .dout  (rsp_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign rsp_valid = ~fifo_empty;

    fifo_within_inflight: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= inflight);
    full_implies_max:     assert property (@(posedge clk) disable iff (!rst_n) fifo_full |-> (inflight == MAX_INFLIGHT));

endmodule

// File: tb/tb_bram_req_ctrl.sv
// Bench for bram_req_ctrl: behavioural BRAM, queue-based reference model,
// a vector table, directed corner sequences and randomized traffic.
module tb_bram_req_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          ram_en, ram_we, ram_rst, ram_en2, ram_rst2;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di, ram_do;

    bram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_rst(ram_rst), .ram_en2(ram_en2), .ram_rst2(ram_rst2), .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    // Single-port read-first BRAM with two registered output stages.
    logic [DW-1:0] ram_mem [1<<AW];
    logic [DW-1:0] do1, do2;
    always @(posedge clk) begin
        if (ram_rst) do1 <= '0;
        else if (ram_en) begin
            do1 <= ram_mem[ram_addr];
            if (ram_we) ram_mem[ram_addr] <= ram_di;
        end
        if (ram_rst2) do2 <= '0;
        else if (ram_en2) do2 <= do1;
    end
    assign ram_do = do2;

    int checks = 0;
    int failures = 0;

    task automatic check_bit(input string name, input bit act, input bit exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory array plus queue of pending responses, each
    // becoming visible three cycles after its load was accepted.
    typedef struct {
        logic [DW-1:0] data;
        int            ready_cyc;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] model_mem [1<<AW];
    int            outstanding = 0;
    int            cyc = 0;
    logic [DW-1:0] seen_q[$];
    int            seen_cyc_q[$];
    int            acc_cnt = 0;
    int            stall_cnt = 0;
    int            last_load_cyc = -1;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i]   = '0;
            model_mem[i] = '0;
        end
    end

    always @(negedge clk) begin : model
        bit   exp_ready;
        bit   exp_rvalid;
        bit   acc;
        rsp_t e;
        if (rst_n && req_valid && req_ready) begin
            acc_cnt++;
            if (!req_we) last_load_cyc = cyc;
        end
        if (rst_n && req_valid && !req_ready) stall_cnt++;
        if (rst_n && rsp_valid && rsp_ready) begin
            seen_q.push_back(rsp_rdata);
            seen_cyc_q.push_back(cyc);
        end
        if (!rst_n) begin
            check_bit("rst_req_ready", req_ready, 1'b0);
            check_bit("rst_rsp_valid", rsp_valid, 1'b0);
            check_word("rst_rsp_rdata", rsp_rdata, '0);
            check_bit("rst_ram_rst", ram_rst, 1'b1);
            check_bit("rst_ram_rst2", ram_rst2, 1'b1);
            check_bit("rst_ram_en", ram_en, 1'b0);
            exp_q.delete();
            outstanding = 0;
        end else begin
            exp_ready  = (outstanding < DEPTH);
            exp_rvalid = (exp_q.size() > 0) && (exp_q[0].ready_cyc <= cyc);
            check_bit("req_ready", req_ready, exp_ready);
            check_bit("rsp_valid", rsp_valid, exp_rvalid);
            if (exp_rvalid) check_word("rsp_rdata", rsp_rdata, exp_q[0].data);
            acc = req_valid && exp_ready;
            check_bit("ram_en", ram_en, acc);
            check_bit("ram_we", ram_we, acc && req_we);
            check_bit("ram_rst", ram_rst, 1'b0);
            check_bit("ram_rst2", ram_rst2, 1'b0);
            if (acc) begin
                check_word("ram_addr", DW'(ram_addr), DW'(req_addr));
                if (req_we) check_word("ram_di", ram_di, req_wdata);
            end
            if (exp_rvalid && rsp_ready) begin
                void'(exp_q.pop_front());
                outstanding--;
            end
            if (acc) begin
                if (req_we) model_mem[req_addr] = req_wdata;
                else begin
                    e.data      = model_mem[req_addr];
                    e.ready_cyc = cyc + 3;
                    exp_q.push_back(e);
                    outstanding++;
                end
            end
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request for exactly one cycle, accepted or not.
    task automatic present(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = d;
        tick(1);
    endtask

    // Hold a request until it is accepted, bounded.
    task automatic do_req(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = d;
        while (!done && n < 50) begin
            @(negedge clk);
            done = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!done) check_bit("req_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_rsp(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (seen_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check_int(name, seen_q.size(), n);
    endtask

    function automatic logic [DW-1:0] seen_at(input int i);
        if (i < seen_q.size()) return seen_q[i];
        return 'x;
    endfunction

    function automatic int seen_cyc_at(input int i);
        if (i < seen_cyc_q.size()) return seen_cyc_q[i];
        return -1000;
    endfunction

    function automatic void clear_seen();
        seen_q.delete();
        seen_cyc_q.delete();
    endfunction

    typedef struct {
        bit            valid;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            exp_en;
        bit            exp_we;
        bit            exp_ready;
    } vec_t;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t vecs[8];
        int   s0;
        int   a0;
        int   ld;

        vecs[0] = '{1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 10'd3,   32'h11,       1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 10'd7,   32'h22,       1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 10'd3,   32'h0,        1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 10'h3FF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 10'h3FF, 32'h0,        1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 10'd0,   32'h0,        1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 10'd0,   32'h0,        1'b0, 1'b0, 1'b1};

        tick(3);
        check_bit("reset_req_ready", req_ready, 1'b0);
        check_bit("reset_rsp_valid", rsp_valid, 1'b0);
        check_word("reset_rsp_rdata", rsp_rdata, '0);
        check_bit("reset_ram_rst", ram_rst, 1'b1);

        // Vector table, starting in the first cycle after reset release.
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        clear_seen();
        for (int i = 0; i < 8; i++) begin
            req_valid = vecs[i].valid;
            req_we    = vecs[i].we;
            req_addr  = vecs[i].addr;
            req_wdata = vecs[i].wdata;
            @(negedge clk);
            check_bit($sformatf("vec%0d_ram_en", i), ram_en, vecs[i].exp_en);
            check_bit($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].exp_we);
            check_bit($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].exp_ready);
            if (vecs[i].valid) check_word($sformatf("vec%0d_ram_addr", i), DW'(ram_addr), DW'(vecs[i].addr));
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wait_rsp(3, 20, "vec_rsp_count");
        check_word("vec_rsp0", seen_at(0), 32'h11);
        check_word("vec_rsp1", seen_at(1), 32'hFFFFFFFF);
        check_word("vec_rsp2", seen_at(2), 32'h0);

        // Store then load: exact 3-cycle latency, no response for the store.
        tick(4);
        clear_seen();
        do_req(1'b1, AW'(5), 32'hDEADBEEF);
        do_req(1'b0, AW'(5), '0);
        ld = last_load_cyc;
        wait_rsp(1, 20, "t1_rsp_count");
        tick(4);
        check_int("t1_only_one_rsp", seen_q.size(), 1);
        check_word("t1_rdata", seen_at(0), 32'hDEADBEEF);
        check_int("t1_latency", seen_cyc_at(0) - ld, 3);

        // Back-to-back loads after a block of stores.
        clear_seen();
        for (int k = 0; k < 8; k++) do_req(1'b1, AW'(k), DW'(k * 3));
        s0 = stall_cnt;
        for (int k = 0; k < 8; k++) do_req(1'b0, AW'(k), '0);
        check_int("t2_no_stall", stall_cnt - s0, 0);
        wait_rsp(8, 30, "t2_rsp_count");
        for (int k = 0; k < 8; k++) begin
            check_word($sformatf("t2_rsp%0d", k), seen_at(k), DW'(k * 3));
            check_int($sformatf("t2_cyc%0d", k), seen_cyc_at(k) - seen_cyc_at(0), k);
        end

        // Backpressure: only DEPTH loads accepted, ready returns after first pop.
        tick(2);
        rsp_ready = 1'b0;
        clear_seen();
        a0 = acc_cnt;
        for (int k = 0; k < 6; k++) present(1'b0, AW'(k), '0);
        req_valid = 1'b0;
        check_int("t3_accepted", acc_cnt - a0, 4);
        check_bit("t3_ready_full", req_ready, 1'b0);
        tick(4);
        check_int("t3_no_rsp_while_blocked", seen_q.size(), 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_bit("t3_ready_pop_cycle", req_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("t3_ready_after_pop", req_ready, 1'b1);
        @(posedge clk);
        #1;
        wait_rsp(4, 20, "t3_rsp_count");
        for (int k = 0; k < 4; k++) check_word($sformatf("t3_rsp%0d", k), seen_at(k), DW'(k * 3));

        // Full FIFO, then continuous accept plus pop across several pointer laps.
        for (int k = 0; k < 24; k++) do_req(1'b1, AW'(100 + k), DW'(k * 7 + 1));
        rsp_ready = 1'b0;
        clear_seen();
        for (int k = 0; k < 4; k++) do_req(1'b0, AW'(100 + k), '0);
        tick(4);
        s0 = stall_cnt;
        rsp_ready = 1'b1;
        for (int k = 4; k < 24; k++) do_req(1'b0, AW'(100 + k), '0);
        check_int("t4_stalls", stall_cnt - s0, 1);
        wait_rsp(24, 40, "t4_rsp_count");
        for (int k = 0; k < 24; k++) check_word($sformatf("t4_rsp%0d", k), seen_at(k), DW'(k * 7 + 1));

        // Store followed immediately by a load of the same address.
        tick(2);
        clear_seen();
        do_req(1'b1, AW'(9), 32'h1);
        do_req(1'b0, AW'(9), '0);
        wait_rsp(1, 20, "t5_rsp_count");
        check_word("t5_rdata", seen_at(0), 32'h1);

        // Reset with loads in the pipeline and in the FIFO.
        do_req(1'b1, AW'(2), 32'h55);
        rsp_ready = 1'b0;
        tick(2);
        for (int k = 0; k < 4; k++) present(1'b0, AW'(20 + k), '0);
        req_valid = 1'b0;
        rst_n = 1'b0;
        clear_seen();
        tick(2);
        check_bit("t6_rst_rsp_valid", rsp_valid, 1'b0);
        check_bit("t6_rst_req_ready", req_ready, 1'b0);
        check_word("t6_rst_rdata", rsp_rdata, '0);
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = AW'(2);
        @(negedge clk);
        check_bit("t6_first_cycle_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        tick(12);
        check_int("t6_rsp_count", seen_q.size(), 1);
        check_word("t6_rdata", seen_at(0), 32'h55);

        // Randomized traffic over a small address window, checked by the model.
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(0, 2) != 0);
            present(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)), DW'($urandom));
            req_valid = ($urandom_range(0, 3) != 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick(12);
        check_bit("final_rsp_valid_idle", rsp_valid, 1'b0);
        check_bit("final_req_ready_idle", req_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
